regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Schedules writes into the 16 x 32 register file, which gets one physical write port driven by this block.
- Two requesters share that port:
  - Rd writeback from the final stage.
  - Rs1 base-register update, e.g. post-increment.
- Requests are queued in a small in-order FIFO and drained one per cycle.
- A read-after-write stall is flagged to the multi-cycle controller while a write to a source register is still pending.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 4, register index width (16 registers).
- QDEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- rd_req_valid  in  1  Rd writeback request.
- rd_req_addr  in  ADDR_W  Rd index.
- rd_req_data  in  DATA_W  Rd data (busWd).
- rd_req_ready  out  1  Rd request accepted when valid and ready are both high.
- rs_req_valid  in  1  Rs1 update request.
- rs_req_addr  in  ADDR_W  Rs1 index.
- rs_req_data  in  DATA_W  Rs1 data (busWs).
- rs_req_ready  out  1  Rs1 request accepted when valid and ready are both high.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write index.
- rf_wdata  out  DATA_W  register file write data.
- chk_addr_a  in  ADDR_W  source index for busA.
- chk_addr_b  in  ADDR_W  source index for busB.
- raw_stall  out  1  pending write to chk_addr_a or chk_addr_b.
- busy  out  1  FIFO not empty.

Behaviour:
- State:
  - FIFO array of {addr, data}.
  - wr_ptr and rd_ptr, each log2(QDEPTH) bits, wrapping modulo QDEPTH.
  - count, log2(QDEPTH)+1 bits.
- Reset:
  - count=0, wr_ptr=0, rd_ptr=0.
  - rf_we=0, busy=0, raw_stall=0.
  - Both readies are high in the first cycle after reset.
  - Reset mid-operation discards all pending entries; no write is issued in the reset cycle.
- Ready rules, computed only from registered count and never from the valids:
  - rd_req_ready = (QDEPTH - count) >= 1.
  - rs_req_ready = (QDEPTH - count) >= 2.
  - Rd is guaranteed progress; Rs1 always has room even if Rd fires in the same cycle.
- Push:
  - rd_fire = rd_req_valid & rd_req_ready.
  - rs_fire = rs_req_valid & rs_req_ready.
  - When both fire in the same cycle, the Rd entry goes to wr_ptr and the Rs1 entry to wr_ptr+1, so the Rd write is issued first.
  - When the addresses are equal, the Rs1 value is the final register content.
- Drain:
  - rf_we = (count != 0); rf_waddr and rf_wdata are taken from the head entry.
  - When rf_we is high, the entry pops at the same edge at which the register file writes it.
- Latency: a request accepted at edge N produces rf_we high during cycle N+1 (FIFO previously empty), so the register holds the new value after edge N+1.
- Count update: count' = count + rd_fire + rs_fire - pop. Push and pop may occur in the same cycle; the pop is not credited to ready in that cycle.
- raw_stall is combinational. It is high when any of the following is true:
  - Any valid FIFO entry's addr equals chk_addr_a or chk_addr_b.
  - rd_fire is high with rd_req_addr equal to either check address.
  - rs_fire is high with rs_req_addr equal to either check address.
- Register 0 is writable and is stalled like any other register.
- Full condition: count == QDEPTH means both readies are low. A valid without ready is held by the requester; this block never drops a request.
- Order: writes are issued strictly in acceptance order, with Rd before Rs1 within a cycle.
- busy = (count != 0).

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=4, REG_DATA_W=32, NUM_REGS=16.
  - Struct wr_entry_t {addr, data}.
- Sub-module: write_fifo, a 2-push/1-pop circular buffer owning the pointers, count and array.
- Top level holds:
  - the ready logic
  - push ordering
  - the raw_stall comparators (QDEPTH x 2 address compares plus the incoming compares).

Test Plan:
- Reset then single request: rd_req (addr 3, 0xDEADBEEF) at edge 1 -> rf_we=1, waddr=3, wdata=0xDEADBEEF in cycle 2; busy=0 in cycle 3.
- Same-cycle pair: rd (5, 0x11), rs (5, 0x22) -> two consecutive writes, 0x11 then 0x22, to register 5; final value 0x22.
- Fill, QDEPTH=4: rd and rs valid every cycle while rf writes are observed -> count never exceeds 4; rs_req_ready=0 at count>=3; rd_req_ready=0 at count=4; no entry lost or reordered.
- RAW stall: pending write to register 7 and chk_addr_a=7 -> raw_stall=1 until the cycle after the last reg-7 write drains; chk_addr 8 -> raw_stall=0.
- Reset mid-operation: 3 entries queued, reset asserted one cycle -> rf_we=0 in the reset cycle and after; count=0; readies=1.
- Wrap-around: 10 sequential single rd requests with addr i, data i*0x100 -> writes in order, pointer wraps, data intact.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared register-file definitions: geometry, the queued write entry and an address-match helper.
package regfile_write_scheduler_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_entry_t;

  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] addr,
                                    input logic [REG_ADDR_W-1:0] chk_a,
                                    input logic [REG_ADDR_W-1:0] chk_b);
    return (addr == chk_a) || (addr == chk_b);
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Requester / register-file / hazard-check signal bundle of the write scheduler.
interface regfile_write_scheduler_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [DATA_W-1:0] rd_req_data;
  logic              rd_req_ready;
  logic              rs_req_valid;
  logic [ADDR_W-1:0] rs_req_addr;
  logic [DATA_W-1:0] rs_req_data;
  logic              rs_req_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] chk_addr_a;
  logic [ADDR_W-1:0] chk_addr_b;
  logic              raw_stall;
  logic              busy;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_data,
    output rs_req_valid, rs_req_addr, rs_req_data,
    output chk_addr_a, chk_addr_b,
    input  rd_req_ready, rs_req_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  raw_stall, busy
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_data,
    input  rs_req_valid, rs_req_addr, rs_req_data,
    input  chk_addr_a, chk_addr_b,
    output rd_req_ready, rs_req_ready,
    output rf_we, rf_waddr, rf_wdata,
    output raw_stall, busy
  );
endinterface

// File: rtl/regfile_write_scheduler_write_fifo.sv
// Two-push / one-pop circular buffer of pending register writes.
module write_fifo
  import regfile_write_scheduler_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PW = $clog2(QDEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push0,
  input  wr_entry_t                push0_entry,
  input  logic                     push1,
  input  wr_entry_t                push1_entry,
  input  logic                     pop,
  output wr_entry_t                head,
  output logic [CW-1:0]            count,
  output wr_entry_t [QDEPTH-1:0]   slots,
  output logic [QDEPTH-1:0]        occupied
);

  wr_entry_t [QDEPTH-1:0] mem;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          cnt;
  logic [1:0]             npush;

  // push1 is only ever raised together with push0
  assign npush = {1'b0, push0} + {1'b0, push1};

  always_ff @(posedge clock) begin
    if (push0) mem[wr_ptr] <= push0_entry;
    if (push1) mem[wr_ptr + PW'(1)] <= push1_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(npush);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(npush) - CW'(pop);
    end
  end

  // A slot is live when its distance from the head is below the fill level
  always_comb begin
    occupied = '0;
    for (int unsigned i = 0; i < QDEPTH; i++)
      occupied[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < cnt);
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign slots = mem;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates Rd writeback and Rs1 update writes onto the single register-file write port.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = $clog2(NUM_REGS),
  parameter int unsigned QDEPTH = 4
) (
  input logic                       clock,
  input logic                       reset,
  regfile_write_scheduler_if.slave  bus
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [CW-1:0]          count;
  wr_entry_t              head;
  wr_entry_t [QDEPTH-1:0] slots;
  logic [QDEPTH-1:0]      occupied;
  logic                   rd_fire;
  logic                   rs_fire;
  wr_entry_t              rd_entry;
  wr_entry_t              rs_entry;
  logic                   push0;
  logic                   push1;
  wr_entry_t              push0_entry;
  logic                   we;
  logic                   stall;
  logic [ADDR_W-1:0]      head_addr;
  logic [DATA_W-1:0]      head_data;

  // Readies look only at the registered fill level; Rs1 needs a spare slot so Rd can fire alongside
  assign bus.rd_req_ready = (count <= CW'(QDEPTH - 1));
  assign bus.rs_req_ready = (count <= CW'(QDEPTH - 2));

  assign rd_fire  = bus.rd_req_valid & bus.rd_req_ready;
  assign rs_fire  = bus.rs_req_valid & bus.rs_req_ready;
  assign rd_entry = '{addr: bus.rd_req_addr, data: bus.rd_req_data};
  assign rs_entry = '{addr: bus.rs_req_addr, data: bus.rs_req_data};

  // Rd always takes the first slot so its write precedes a same-cycle Rs1 write
  assign push0       = rd_fire | rs_fire;
  assign push1       = rd_fire & rs_fire;
  assign push0_entry = rd_fire ? rd_entry : rs_entry;

  assign we = ~reset & (count != '0);

  write_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push0       (push0),
    .push0_entry (push0_entry),
    .push1       (push1),
    .push1_entry (rs_entry),
    .pop         (we),
    .head        (head),
    .count       (count),
    .slots       (slots),
    .occupied    (occupied)
  );

  assign head_addr    = head.addr;
  assign head_data    = head.data;
  assign bus.rf_we    = we;
  assign bus.rf_waddr = head_addr;
  assign bus.rf_wdata = head_data;
  assign bus.busy     = (count != '0);

  always_comb begin
    stall = 1'b0;
    for (int unsigned i = 0; i < QDEPTH; i++)
      if (occupied[i] && addr_hit(slots[i].addr, bus.chk_addr_a, bus.chk_addr_b))
        stall = 1'b1;
    if (rd_fire && addr_hit(bus.rd_req_addr, bus.chk_addr_a, bus.chk_addr_b))
      stall = 1'b1;
    if (rs_fire && addr_hit(bus.rs_req_addr, bus.chk_addr_a, bus.chk_addr_b))
      stall = 1'b1;
  end

  assign bus.raw_stall = stall & ~reset;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized scoreboard bench for regfile_write_scheduler against a queue-based reference model.
module tb_regfile_write_scheduler;
  import regfile_write_scheduler_pkg::*;

  localparam int unsigned QDEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_write_scheduler_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  regfile_write_scheduler #(.DATA_W(32), .ADDR_W(4), .QDEPTH(QDEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  wr_entry_t   pend_q[$];
  wr_entry_t   exp_q[$];
  logic [31:0] mdl_rf [16] = '{default: '0};
  logic [31:0] tb_rf  [16] = '{default: '0};

  logic        rst_d = 1'b1;
  logic        f_rd  = 1'b0;
  logic        f_rs  = 1'b0;
  wr_entry_t   e_rd, e_rs;

  logic        cur_rv = 1'b0, cur_sv = 1'b0;
  logic [3:0]  cur_ra = '0, cur_sa = '0, cur_ca = '0, cur_cb = '0;
  logic [31:0] cur_rdat = '0, cur_sdat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Stand-in register file fed by the DUT write port
  always @(posedge clock)
    if (bus.rf_we === 1'b1) tb_rf[bus.rf_waddr] <= bus.rf_wdata;

  // Scoreboard monitor: every issued write must match the oldest accepted request
  always @(negedge clock) begin
    wr_entry_t e;
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
        chk("rf_wdata", bus.rf_wdata, e.data);
      end
    end
  end

  task automatic step(input logic rst);
    int unsigned free;
    logic        s;
    wr_entry_t   h;
    @(posedge clock);
    if (rst_d) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (pend_q.size() != 0) begin
        h = pend_q.pop_front();
        mdl_rf[h.addr] = h.data;
      end
      if (f_rd) begin pend_q.push_back(e_rd); exp_q.push_back(e_rd); end
      if (f_rs) begin pend_q.push_back(e_rs); exp_q.push_back(e_rs); end
    end
    #1;
    reset            = rst;
    bus.rd_req_valid = cur_rv;
    bus.rd_req_addr  = cur_ra;
    bus.rd_req_data  = cur_rdat;
    bus.rs_req_valid = cur_sv;
    bus.rs_req_addr  = cur_sa;
    bus.rs_req_data  = cur_sdat;
    bus.chk_addr_a   = cur_ca;
    bus.chk_addr_b   = cur_cb;
    rst_d = rst;
    free  = QDEPTH - pend_q.size();
    e_rd  = '{addr: cur_ra, data: cur_rdat};
    e_rs  = '{addr: cur_sa, data: cur_sdat};
    f_rd  = cur_rv && (free >= 1) && !rst;
    f_rs  = cur_sv && (free >= 2) && !rst;
    s = 1'b0;
    if (!rst) begin
      foreach (pend_q[i])
        if (pend_q[i].addr == cur_ca || pend_q[i].addr == cur_cb) s = 1'b1;
      if (f_rd && (cur_ra == cur_ca || cur_ra == cur_cb)) s = 1'b1;
      if (f_rs && (cur_sa == cur_ca || cur_sa == cur_cb)) s = 1'b1;
    end
    @(negedge clock);
    chk("rd_req_ready", 32'(bus.rd_req_ready), 32'(free >= 1));
    chk("rs_req_ready", 32'(bus.rs_req_ready), 32'(free >= 2));
    chk("rf_we",        32'(bus.rf_we),        32'(!rst && pend_q.size() != 0));
    chk("busy",         32'(bus.busy),         32'(pend_q.size() != 0));
    chk("raw_stall",    32'(bus.raw_stall),    32'(s));
  endtask

  // New random request unless the previous one is still waiting for ready
  task automatic gen(input int unsigned prd, input int unsigned prs, input int unsigned amax);
    if (!(cur_rv && !f_rd)) begin
      cur_rv   = ($urandom_range(99) < prd);
      cur_ra   = 4'($urandom_range(amax));
      cur_rdat = $urandom;
    end
    if (!(cur_sv && !f_rs)) begin
      cur_sv   = ($urandom_range(99) < prs);
      cur_sa   = 4'($urandom_range(amax));
      cur_sdat = $urandom;
    end
  endtask

  task automatic idle(input int unsigned n);
    cur_rv = 1'b0;
    cur_sv = 1'b0;
    for (int unsigned i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rd_req_valid = 1'b0; bus.rd_req_addr = '0; bus.rd_req_data = '0;
    bus.rs_req_valid = 1'b0; bus.rs_req_addr = '0; bus.rs_req_data = '0;
    bus.chk_addr_a = '0; bus.chk_addr_b = '0;

    step(1'b1); step(1'b1);
    cur_ca = 4'd14; cur_cb = 4'd15;
    idle(2);

    // single Rd request, one-cycle latency
    cur_rv = 1'b1; cur_ra = 4'd3; cur_rdat = 32'hDEADBEEF;
    step(1'b0);
    idle(3);
    chk("reg3_single", tb_rf[3], 32'hDEADBEEF);

    // same-cycle pair to the same register: Rs1 wins
    cur_rv = 1'b1; cur_ra = 4'd5; cur_rdat = 32'h11;
    cur_sv = 1'b1; cur_sa = 4'd5; cur_sdat = 32'h22;
    step(1'b0);
    idle(4);
    chk("reg5_pair", tb_rf[5], 32'h22);

    // fill: both requesters valid every cycle
    for (int unsigned i = 0; i < 16; i++) begin gen(100, 100, 15); step(1'b0); end
    idle(8);

    // RAW stall on register 7, then non-matching check addresses
    cur_ca = 4'd7; cur_cb = 4'd8;
    cur_rv = 1'b1; cur_ra = 4'd7; cur_rdat = 32'h7000_0001;
    cur_sv = 1'b1; cur_sa = 4'd2; cur_sdat = 32'h2000_0001;
    step(1'b0);
    cur_sv = 1'b0; cur_ra = 4'd7; cur_rdat = 32'h7000_0002;
    step(1'b0);
    idle(5);
    cur_ca = 4'd8; cur_cb = 4'd9;
    cur_rv = 1'b1; cur_ra = 4'd0; cur_rdat = 32'h0000_0AAA;
    step(1'b0);
    idle(3);

    // reset with three entries pending
    cur_ca = 4'd1; cur_cb = 4'd6;
    cur_rv = 1'b1; cur_ra = 4'd1; cur_rdat = 32'hA1;
    cur_sv = 1'b1; cur_sa = 4'd6; cur_sdat = 32'hA6;
    step(1'b0);
    cur_ra = 4'd9; cur_rdat = 32'hA9; cur_sa = 4'd10; cur_sdat = 32'hAA;
    step(1'b0);
    cur_rv = 1'b0; cur_sv = 1'b0;
    step(1'b1);
    idle(3);

    // wrap-around with sequential single Rd requests
    for (int unsigned i = 0; i < 10; i++) begin
      cur_rv = 1'b1; cur_ra = 4'(i); cur_rdat = 32'(i * 32'h100);
      step(1'b0);
    end
    idle(3);

    // random traffic with occasional reset
    for (int unsigned i = 0; i < 400; i++) begin
      gen(70, 50, 5);
      cur_ca = 4'($urandom_range(5));
      cur_cb = 4'($urandom_range(15));
      step($urandom_range(99) < 2);
    end
    idle(8);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    for (int unsigned r = 0; r < 16; r++) chk($sformatf("reg%0d_final", r), tb_rf[r], mdl_rf[r]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
